// File: rtl/mips_alu_if.sv
// ============================================================================
// Module  : mips_alu_if
// Brief   : Operand/control bundle between the EX-stage glue and mips_alu.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface mips_alu_if;
  logic        in_valid;
  logic [4:0]  in_alu_ctl;
  logic [31:0] in_op1;
  logic [31:0] in_op2;
  logic        out_valid;
  logic [31:0] out_result;
  logic        out_branch_outcome;
  logic        done;
  logic        pass;

  modport master (
    output in_valid, in_alu_ctl, in_op1, in_op2,
    input  out_valid, out_result, out_branch_outcome, done, pass
  );

  modport slave (
    input  in_valid, in_alu_ctl, in_op1, in_op2,
    output out_valid, out_result, out_branch_outcome, done, pass
  );
endinterface

`default_nettype wire

// File: rtl/mips_alu.sv
// ============================================================================
// Module  : mips_alu
// Brief   : MIPS32 execute-stage ALU with branch resolution and MTC0 flags.
// Revision: 1.0
// ============================================================================
`default_nettype none

module mips_alu (
  input  wire logic    clk,
  input  wire logic    rst,
  mips_alu_if.slave    bus
);

  localparam logic [4:0] c_NOP       = 5'd0;
  localparam logic [4:0] c_ADD       = 5'd1;
  localparam logic [4:0] c_ADDU      = 5'd2;
  localparam logic [4:0] c_SUB       = 5'd3;
  localparam logic [4:0] c_SUBU      = 5'd4;
  localparam logic [4:0] c_AND       = 5'd5;
  localparam logic [4:0] c_OR        = 5'd6;
  localparam logic [4:0] c_XOR       = 5'd7;
  localparam logic [4:0] c_SLT       = 5'd8;
  localparam logic [4:0] c_SLTU      = 5'd9;
  localparam logic [4:0] c_SLL       = 5'd10;
  localparam logic [4:0] c_SRL       = 5'd11;
  localparam logic [4:0] c_SRA       = 5'd12;
  localparam logic [4:0] c_SLLV      = 5'd13;
  localparam logic [4:0] c_SRLV      = 5'd14;
  localparam logic [4:0] c_SRAV      = 5'd15;
  localparam logic [4:0] c_LUI       = 5'd16;
  localparam logic [4:0] c_MTC0_PASS = 5'd18;
  localparam logic [4:0] c_MTC0_FAIL = 5'd19;
  localparam logic [4:0] c_MTC0_DONE = 5'd20;
  localparam logic [4:0] c_BA        = 5'd21;
  localparam logic [4:0] c_BEQ       = 5'd22;
  localparam logic [4:0] c_BNE       = 5'd23;
  localparam logic [4:0] c_BLEZ      = 5'd24;
  localparam logic [4:0] c_BGTZ      = 5'd25;
  localparam logic [4:0] c_BGEZ      = 5'd26;
  localparam logic [4:0] c_BLTZ      = 5'd27;

  logic [31:0] w_op1;
  logic [31:0] w_op2;
  logic [4:0]  w_shamt;
  logic        w_op1_neg;
  logic        w_op1_zero;
  logic [31:0] w_result;
  logic        w_taken;
  logic        r_done;
  logic        r_pass;

  assign w_op1      = bus.in_op1;
  assign w_op2      = bus.in_op2;
  assign w_shamt    = w_op2[4:0];
  assign w_op1_neg  = w_op1[31];
  assign w_op1_zero = (w_op1 == 32'd0);

  // MTC0 and NOP codes fall through to the zero default.
  always_comb begin
    w_result = 32'd0;
    w_taken  = 1'b0;
    if (bus.in_valid) begin
      case (bus.in_alu_ctl)
        c_ADD, c_ADDU: w_result = w_op1 + w_op2;
        c_SUB, c_SUBU: w_result = w_op1 - w_op2;
        c_AND:         w_result = w_op1 & w_op2;
        c_OR:          w_result = w_op1 | w_op2;
        c_XOR:         w_result = w_op1 ^ w_op2;
        c_SLT:         w_result = {31'd0, ($signed(w_op1) < $signed(w_op2))};
        c_SLTU:        w_result = {31'd0, (w_op1 < w_op2)};
        c_SLL, c_SLLV: w_result = w_op1 << w_shamt;
        c_SRL, c_SRLV: w_result = w_op1 >> w_shamt;
        c_SRA, c_SRAV: w_result = $unsigned($signed(w_op1) >>> w_shamt);
        c_LUI:         w_result = {w_op2[15:0], 16'h0000};
        c_BA:          w_taken  = 1'b1;
        c_BEQ:         w_taken  = (w_op1 == w_op2);
        c_BNE:         w_taken  = (w_op1 != w_op2);
        c_BLEZ:        w_taken  = w_op1_neg | w_op1_zero;
        c_BGTZ:        w_taken  = ~w_op1_neg & ~w_op1_zero;
        c_BGEZ:        w_taken  = ~w_op1_neg;
        c_BLTZ:        w_taken  = w_op1_neg;
        default:       w_result = 32'd0;
      endcase
    end
  end

  // Test-completion flags: done is sticky, pass follows the last PASS/FAIL.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_done <= 1'b0;
      r_pass <= 1'b0;
    end else if (bus.in_valid) begin
      case (bus.in_alu_ctl)
        c_MTC0_PASS: r_pass <= 1'b1;
        c_MTC0_FAIL: r_pass <= 1'b0;
        c_MTC0_DONE: r_done <= 1'b1;
        default:     r_done <= r_done;
      endcase
    end
  end

  assign bus.out_valid          = bus.in_valid;
  assign bus.out_result         = w_result;
  assign bus.out_branch_outcome = w_taken;
  assign bus.done               = r_done;
  assign bus.pass               = r_pass;

endmodule

`default_nettype wire

// File: tb/tb_mips_alu.sv
// ============================================================================
// Module  : tb_mips_alu
// Brief   : Directed self-checking bench for mips_alu against a reference model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_mips_alu;

  logic clk;
  logic rst;
  mips_alu_if bus ();

  mips_alu dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  bit started = 1'b0;

  // Reference: result and branch outcome straight from the opcode table.
  function automatic logic [32:0] ref_eval(input logic v, input logic [4:0] op,
                                           input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    logic        t;
    int          sa;
    longint      sa_s;
    r  = 0;
    t  = 0;
    sa = int'(b % 32);
    sa_s = longint'($signed(a));
    if (v) begin
      if (op == 1 || op == 2) r = a + b;
      else if (op == 3 || op == 4) r = a - b;
      else if (op == 5) r = a & b;
      else if (op == 6) r = a | b;
      else if (op == 7) r = a ^ b;
      else if (op == 8) r = (sa_s < longint'($signed(b))) ? 32'd1 : 32'd0;
      else if (op == 9) r = (longint'(a) < longint'(b)) ? 32'd1 : 32'd0;
      else if (op == 10 || op == 13) r = 32'(longint'(a) * (64'd1 << sa));
      else if (op == 11 || op == 14) r = 32'(longint'(a) / (64'd1 << sa));
      else if (op == 12 || op == 15) r = 32'(sa_s >>> sa);
      else if (op == 16) r = (b % 65536) * 65536;
      else if (op == 21) t = 1;
      else if (op == 22) t = (a == b);
      else if (op == 23) t = (a != b);
      else if (op == 24) t = (sa_s <= 0);
      else if (op == 25) t = (sa_s > 0);
      else if (op == 26) t = (sa_s >= 0);
      else if (op == 27) t = (sa_s < 0);
    end
    return {t, r};
  endfunction

  logic m_done, m_pass;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_done <= 0;
      m_pass <= 0;
    end else if (bus.in_valid) begin
      if (bus.in_alu_ctl == 5'd18) m_pass <= 1;
      if (bus.in_alu_ctl == 5'd19) m_pass <= 0;
      if (bus.in_alu_ctl == 5'd20) m_done <= 1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Model compare every mid-cycle.
  always @(negedge clk) begin
    logic [32:0] e;
    if (started) begin
      e = ref_eval(bus.in_valid, bus.in_alu_ctl, bus.in_op1, bus.in_op2);
      check("model_result", bus.out_result, e[31:0]);
      check("model_branch", 32'(bus.out_branch_outcome), 32'(e[32]));
      check("model_valid", 32'(bus.out_valid), 32'(bus.in_valid));
      check("model_done", 32'(bus.done), 32'(m_done));
      check("model_pass", 32'(bus.pass), 32'(m_pass));
    end
  end

  task automatic apply(input logic v, input logic [4:0] op,
                       input logic [31:0] a, input logic [31:0] b);
    @(posedge clk);
    #2;
    bus.in_valid   = v;
    bus.in_alu_ctl = op;
    bus.in_op1     = a;
    bus.in_op2     = b;
    #1;
  endtask

  typedef struct {
    string       name;
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        br;
  } vec_t;

  vec_t vecs[$];

  initial begin
    vecs.push_back('{"add_ovf",  5'd1,  32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0});
    vecs.push_back('{"subu_wrap",5'd4,  32'h00000000, 32'h00000001, 32'hFFFFFFFF, 1'b0});
    vecs.push_back('{"slt_neg",  5'd8,  32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0});
    vecs.push_back('{"sltu_big", 5'd9,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0});
    vecs.push_back('{"sra_4",    5'd12, 32'h80000000, 32'h00000024, 32'hF8000000, 1'b0});
    vecs.push_back('{"srl_4",    5'd11, 32'h80000000, 32'h00000024, 32'h08000000, 1'b0});
    vecs.push_back('{"sllv_8",   5'd13, 32'h000000AB, 32'hFFFFFFE8, 32'h0000AB00, 1'b0});
    vecs.push_back('{"srav_31",  5'd15, 32'h40000000, 32'h0000001F, 32'h00000000, 1'b0});
    vecs.push_back('{"lui",      5'd16, 32'hDEADBEEF, 32'h00001234, 32'h12340000, 1'b0});
    vecs.push_back('{"xor",      5'd7,  32'hFF00FF00, 32'h0F0F0F0F, 32'hF00FF00F, 1'b0});
    vecs.push_back('{"and",      5'd5,  32'hFF00FF00, 32'h0F0F0F0F, 32'h0F000F00, 1'b0});
    vecs.push_back('{"or",       5'd6,  32'hFF00FF00, 32'h0F0F0F0F, 32'hFF0FFF0F, 1'b0});
    vecs.push_back('{"sub",      5'd3,  32'h00000005, 32'h00000007, 32'hFFFFFFFE, 1'b0});
    vecs.push_back('{"blez_0",   5'd24, 32'h00000000, 32'h00000000, 32'h00000000, 1'b1});
    vecs.push_back('{"bgtz_0",   5'd25, 32'h00000000, 32'h00000000, 32'h00000000, 1'b0});
    vecs.push_back('{"bgez_0",   5'd26, 32'h00000000, 32'h00000000, 32'h00000000, 1'b1});
    vecs.push_back('{"bltz_0",   5'd27, 32'h00000000, 32'h00000000, 32'h00000000, 1'b0});
    vecs.push_back('{"bltz_neg", 5'd27, 32'h80000000, 32'h00000000, 32'h00000000, 1'b1});
    vecs.push_back('{"bgtz_pos", 5'd25, 32'h00000001, 32'h00000000, 32'h00000000, 1'b1});
    vecs.push_back('{"beq_5",    5'd22, 32'h00000005, 32'h00000005, 32'h00000000, 1'b1});
    vecs.push_back('{"bne_5",    5'd23, 32'h00000005, 32'h00000005, 32'h00000000, 1'b0});
    vecs.push_back('{"ba",       5'd21, 32'h00000000, 32'h00000000, 32'h00000000, 1'b1});
    vecs.push_back('{"code30",   5'd30, 32'h12345678, 32'h11111111, 32'h00000000, 1'b0});

    rst            = 1'b1;
    bus.in_valid   = 1'b0;
    bus.in_alu_ctl = 5'd0;
    bus.in_op1     = 32'd0;
    bus.in_op2     = 32'd0;
    repeat (2) @(posedge clk);
    #2;
    started = 1'b1;
    rst     = 1'b0;
    check("reset_done", 32'(bus.done), 32'd0);
    check("reset_pass", 32'(bus.pass), 32'd0);

    foreach (vecs[i]) begin
      apply(1'b1, vecs[i].op, vecs[i].a, vecs[i].b);
      check({vecs[i].name, "_res"}, bus.out_result, vecs[i].res);
      check({vecs[i].name, "_br"}, 32'(bus.out_branch_outcome), 32'(vecs[i].br));
      check({vecs[i].name, "_vld"}, 32'(bus.out_valid), 32'd1);
    end

    // Invalid cycles must neither compute nor touch the flags.
    apply(1'b0, 5'd20, 32'd0, 32'd0);
    apply(1'b0, 5'd1, 32'd1, 32'd1);
    check("inv_add_res", bus.out_result, 32'd0);
    check("inv_add_vld", 32'(bus.out_valid), 32'd0);
    check("inv_done", 32'(bus.done), 32'd0);

    apply(1'b1, 5'd18, 32'd0, 32'd0);
    apply(1'b1, 5'd20, 32'd0, 32'd0);
    apply(1'b1, 5'd17, 32'd0, 32'd0);
    check("flag_done_set", 32'(bus.done), 32'd1);
    check("flag_pass_set", 32'(bus.pass), 32'd1);

    apply(1'b1, 5'd19, 32'd0, 32'd0);
    apply(1'b1, 5'd19, 32'd0, 32'd0);
    apply(1'b0, 5'd18, 32'd0, 32'd0);
    check("fail_pass_clr", 32'(bus.pass), 32'd0);
    check("fail_done_hold", 32'(bus.done), 32'd1);

    apply(1'b1, 5'd18, 32'd0, 32'd0);
    apply(1'b1, 5'd18, 32'd0, 32'd0);
    check("repass", 32'(bus.pass), 32'd1);
    // Reset asserted between edges clears flags without a clock.
    rst = 1'b1;
    #1;
    check("async_rst_done", 32'(bus.done), 32'd0);
    check("async_rst_pass", 32'(bus.pass), 32'd0);
    apply(1'b1, 5'd20, 32'd0, 32'd0);
    apply(1'b1, 5'd1, 32'd2, 32'd3);
    check("rst_hold_done", 32'(bus.done), 32'd0);
    check("rst_add_res", bus.out_result, 32'd5);
    rst = 1'b0;
    apply(1'b1, 5'd0, 32'd0, 32'd0);
    @(negedge clk);
    #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
